// File: rtl/mcyc_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit: FSM states, instruction
// fields, exception codes and datapath select codes.
package mcyc_pkg;

    typedef enum logic [3:0] {
        StFetch  = 4'd0,
        StDecode = 4'd1,
        StMadr   = 4'd2,
        StMrd    = 4'd3,
        StMwb    = 4'd4,
        StMwr    = 4'd5,
        StExe    = 4'd6,
        StAwb    = 4'd7,
        StBr     = 4'd8,
        StJmp    = 4'd9,
        StExc    = 4'd10
    } state_e;

    typedef enum logic [2:0] {
        IcLoad, IcStore, IcMfc0, IcMtc0, IcAlu, IcBranch, IcJump, IcRsvd
    } iclass_e;

    localparam logic [5:0] OpRtype = 6'b000000;
    localparam logic [5:0] OpJ     = 6'b000010;
    localparam logic [5:0] OpJal   = 6'b000011;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpAddi  = 6'b001000;
    localparam logic [5:0] OpAddiu = 6'b001001;
    localparam logic [5:0] OpOri   = 6'b001101;
    localparam logic [5:0] OpLui   = 6'b001111;
    localparam logic [5:0] OpCop0  = 6'b010000;
    localparam logic [5:0] OpLb    = 6'b100000;
    localparam logic [5:0] OpLw    = 6'b100011;
    localparam logic [5:0] OpSb    = 6'b101000;
    localparam logic [5:0] OpSw    = 6'b101011;

    localparam logic [5:0] FnJr    = 6'b001000;
    localparam logic [5:0] FnEret  = 6'b011000;
    localparam logic [5:0] FnAddu  = 6'b100001;
    localparam logic [5:0] FnSubu  = 6'b100011;
    localparam logic [5:0] FnSlt   = 6'b101010;

    localparam logic [4:0] MfMfc0  = 5'b00000;
    localparam logic [4:0] MfMtc0  = 5'b00100;
    localparam logic [4:0] MfCo    = 5'b10000;

    localparam logic [4:0] ExcInt  = 5'd0;
    localparam logic [4:0] ExcRi   = 5'd10;
    localparam logic [4:0] ExcOv   = 5'd12;

    localparam logic [2:0] AluAdd  = 3'b000;
    localparam logic [2:0] AluSub  = 3'b001;
    localparam logic [2:0] AluOr   = 3'b010;
    localparam logic [2:0] AluSlt  = 3'b011;
    localparam logic [2:0] AluAddi = 3'b100;

    localparam logic [2:0] WdAlu   = 3'b000;
    localparam logic [2:0] WdDm    = 3'b001;
    localparam logic [2:0] WdPc4   = 3'b010;
    localparam logic [2:0] WdCp0   = 3'b100;

    localparam logic [1:0] GprRt   = 2'b00;
    localparam logic [1:0] GprRd   = 2'b01;
    localparam logic [1:0] GprRa   = 2'b10;
    localparam logic [1:0] GprR30  = 2'b11;

    localparam logic [1:0] ExtZero = 2'b00;
    localparam logic [1:0] ExtSign = 2'b01;
    localparam logic [1:0] ExtLui  = 2'b10;

    localparam logic [1:0] NpcPc4  = 2'b00;
    localparam logic [1:0] NpcBr   = 2'b01;
    localparam logic [1:0] NpcJ    = 2'b10;
    localparam logic [1:0] NpcReg  = 2'b11;

    // Index of the lowest set bit; 0 when the vector is empty.
    function automatic logic [4:0] lowest_set(input logic [31:0] v);
        logic [4:0] idx;
        idx = 5'd0;
        for (int i = 31; i >= 0; i--) begin
            if (v[i]) idx = 5'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/mcyc_decode.sv
// Combinational instruction-class and datapath-select decode from opcode/funct/mf.
module mcyc_decode
    import mcyc_pkg::*;
#(
    parameter bit TRAP_OV = 1'b1
) (
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic [4:0] mf,
    input  logic       overflow,
    output iclass_e    iclass,
    output logic       is_addi,
    output logic       is_jal,
    output logic       is_eret,
    output logic [2:0] aluop,
    output logic [1:0] extop,
    output logic       bsel,
    output logic [2:0] wdsel,
    output logic [1:0] gprsel,
    output logic [1:0] npcop
);

    always_comb begin
        iclass  = IcRsvd;
        is_addi = 1'b0;
        is_jal  = 1'b0;
        is_eret = 1'b0;
        aluop   = AluAdd;
        extop   = ExtSign;
        bsel    = 1'b0;
        wdsel   = WdAlu;
        gprsel  = GprRt;
        npcop   = NpcPc4;
        case (opcode)
            OpRtype: begin
                gprsel = GprRd;
                case (funct)
                    FnAddu: iclass = IcAlu;
                    FnSubu: begin iclass = IcAlu; aluop = AluSub; end
                    FnSlt:  begin iclass = IcAlu; aluop = AluSlt; end
                    FnJr:   begin iclass = IcJump; npcop = NpcReg; end
                    default: ;
                endcase
            end
            OpOri:   begin iclass = IcAlu; aluop = AluOr; extop = ExtZero; bsel = 1'b1; end
            OpLui:   begin iclass = IcAlu; aluop = AluOr; extop = ExtLui; bsel = 1'b1; end
            OpAddiu: begin iclass = IcAlu; bsel = 1'b1; end
            OpAddi: begin
                iclass  = IcAlu;
                aluop   = AluAddi;
                bsel    = 1'b1;
                is_addi = 1'b1;
                // Without trapping, the overflowed sum lands in $30
                if (overflow && !TRAP_OV) gprsel = GprR30;
            end
            OpLw, OpLb: begin iclass = IcLoad; bsel = 1'b1; wdsel = WdDm; end
            OpSw, OpSb: begin iclass = IcStore; bsel = 1'b1; end
            OpBeq: begin iclass = IcBranch; aluop = AluSub; npcop = NpcBr; end
            OpJ:   begin iclass = IcJump; npcop = NpcJ; end
            OpJal: begin
                iclass = IcJump;
                npcop  = NpcJ;
                gprsel = GprRa;
                wdsel  = WdPc4;
                is_jal = 1'b1;
            end
            OpCop0: begin
                case (mf)
                    MfMfc0: begin iclass = IcMfc0; wdsel = WdCp0; end
                    MfMtc0: iclass = IcMtc0;
                    MfCo: begin
                        if (funct == FnEret) begin
                            iclass  = IcJump;
                            npcop   = NpcReg;
                            is_eret = 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mcyc_ctrl_ext.sv
// Multi-cycle MIPS control FSM with memory handshake, overflow trap and masked
// interrupts taken only at instruction completion.
module mcyc_ctrl_ext
    import mcyc_pkg::*;
#(
    parameter int unsigned N_INT   = 6,
    parameter bit          MEM_HS  = 1'b1,
    parameter bit          TRAP_OV = 1'b1,
    localparam int unsigned IdW    = (N_INT > 1) ? $clog2(N_INT) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic [4:0]       mf,
    input  logic             zero,
    input  logic             overflow,
    input  logic [N_INT-1:0] int_req,
    input  logic [N_INT-1:0] int_mask,
    input  logic             exl,
    input  logic             mem_rdy,
    output logic [2:0]       aluop,
    output logic [1:0]       extop,
    output logic             bsel,
    output logic [2:0]       wdsel,
    output logic [1:0]       gprsel,
    output logic [1:0]       npcop,
    output logic             gprwr,
    output logic             pcwr,
    output logic             irwr,
    output logic             dmwr,
    output logic             mem_req,
    output logic             cp0_wen,
    output logic             exl_set,
    output logic             exl_clr,
    output logic             int_pc,
    output logic [4:0]       exc_code,
    output logic [IdW-1:0]   irq_id,
    output logic [3:0]       state
);

    state_e           state_q, state_d;
    logic [4:0]       exc_code_q, exc_code_d;
    logic [IdW-1:0]   irq_id_q, irq_id_d;
    iclass_e          iclass;
    logic             is_addi, is_jal, is_eret;
    logic [1:0]       dec_npcop;
    logic [N_INT-1:0] pend;
    logic             irq_take, rdy, done, exc_enter;
    logic [4:0]       exc_cause;
    logic gprwr_c, pcwr_c, irwr_c, dmwr_c, mem_req_c, cp0_wen_c, exl_set_c, exl_clr_c, int_pc_c;

    mcyc_decode #(
        .TRAP_OV (TRAP_OV)
    ) u_decode (
        .opcode   (opcode),
        .funct    (funct),
        .mf       (mf),
        .overflow (overflow),
        .iclass   (iclass),
        .is_addi  (is_addi),
        .is_jal   (is_jal),
        .is_eret  (is_eret),
        .aluop    (aluop),
        .extop    (extop),
        .bsel     (bsel),
        .wdsel    (wdsel),
        .gprsel   (gprsel),
        .npcop    (dec_npcop)
    );

    assign pend     = int_req & int_mask;
    assign irq_take = (|pend) && !exl;
    assign rdy      = mem_rdy || !MEM_HS;

    always_comb begin
        state_d    = state_q;
        exc_code_d = exc_code_q;
        irq_id_d   = irq_id_q;
        gprwr_c    = 1'b0;
        pcwr_c     = 1'b0;
        irwr_c     = 1'b0;
        dmwr_c     = 1'b0;
        mem_req_c  = 1'b0;
        cp0_wen_c  = 1'b0;
        exl_set_c  = 1'b0;
        exl_clr_c  = 1'b0;
        int_pc_c   = 1'b0;
        done       = 1'b0;
        exc_enter  = 1'b0;
        exc_cause  = ExcInt;
        case (state_q)
            StFetch: begin
                mem_req_c = 1'b1;
                if (rdy) begin
                    irwr_c  = 1'b1;
                    pcwr_c  = 1'b1;
                    state_d = StDecode;
                end
            end
            StDecode: begin
                case (iclass)
                    IcLoad, IcStore, IcMfc0, IcMtc0: state_d = StMadr;
                    IcAlu:    state_d = StExe;
                    IcBranch: state_d = StBr;
                    IcJump:   state_d = StJmp;
                    default: begin exc_enter = 1'b1; exc_cause = ExcRi; end
                endcase
            end
            StMadr: state_d = (iclass == IcLoad || iclass == IcMfc0) ? StMrd : StMwr;
            StMrd: begin
                if (iclass == IcMfc0) begin
                    state_d = StMwb;
                end else begin
                    mem_req_c = 1'b1;
                    if (rdy) state_d = StMwb;
                end
            end
            StMwb: begin gprwr_c = 1'b1; done = 1'b1; end
            StMwr: begin
                if (iclass == IcMtc0) begin
                    cp0_wen_c = 1'b1;
                    done      = 1'b1;
                end else begin
                    dmwr_c    = 1'b1;
                    mem_req_c = 1'b1;
                    done      = rdy;
                end
            end
            StExe: state_d = StAwb;
            StAwb: begin
                if (is_addi && overflow && TRAP_OV) begin
                    exc_enter = 1'b1;
                    exc_cause = ExcOv;
                end else begin
                    gprwr_c = 1'b1;
                    done    = 1'b1;
                end
            end
            StBr:  begin pcwr_c = zero; done = 1'b1; end
            StJmp: begin
                pcwr_c    = 1'b1;
                gprwr_c   = is_jal;
                exl_clr_c = is_eret;
                done      = 1'b1;
            end
            StExc: begin
                pcwr_c    = 1'b1;
                int_pc_c  = 1'b1;
                exl_set_c = 1'b1;
                state_d   = StFetch;
            end
            default: state_d = StFetch;
        endcase
        if (done) begin
            // exl is still set while eret retires, so eret itself never traps
            if (irq_take && !(state_q == StJmp && is_eret)) begin
                exc_enter = 1'b1;
                exc_cause = ExcInt;
            end else begin
                state_d = StFetch;
            end
        end
        if (exc_enter) begin
            state_d    = StExc;
            exc_code_d = exc_cause;
            irq_id_d   = IdW'(lowest_set(32'(pend)));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StFetch;
            exc_code_q <= '0;
            irq_id_q   <= '0;
        end else begin
            state_q    <= state_d;
            exc_code_q <= exc_code_d;
            irq_id_q   <= irq_id_d;
        end
    end

    // Strobes are gated by reset so an in-flight access is dropped immediately
    assign gprwr    = gprwr_c & rst_n;
    assign pcwr     = pcwr_c & rst_n;
    assign irwr     = irwr_c & rst_n;
    assign dmwr     = dmwr_c & rst_n;
    assign mem_req  = mem_req_c & rst_n;
    assign cp0_wen  = cp0_wen_c & rst_n;
    assign exl_set  = exl_set_c & rst_n;
    assign exl_clr  = exl_clr_c & rst_n;
    assign int_pc   = int_pc_c & rst_n;
    assign npcop    = (state_q == StFetch) ? NpcPc4 : dec_npcop;
    assign exc_code = exc_code_q;
    assign irq_id   = irq_id_q;
    assign state    = state_q;

endmodule

// File: tb/tb_mcyc_ctrl_ext.sv
// Directed bench for mcyc_ctrl_ext: handshake fetch, overflow trap in both modes,
// interrupt on store completion, reserved opcode, eret deferral and async reset.
module tb_mcyc_ctrl_ext;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [5:0] opcode = 6'd0;
    logic [5:0] funct = 6'd0;
    logic [4:0] mf = 5'd0;
    logic       zero = 1'b0;
    logic       overflow = 1'b0;
    logic [5:0] int_req = 6'd0;
    logic [5:0] int_mask = 6'd0;
    logic       exl = 1'b0;
    logic       mem_rdy = 1'b0;

    logic [2:0] aluop, aluop2;
    logic [1:0] extop, extop2;
    logic       bsel, bsel2;
    logic [2:0] wdsel, wdsel2;
    logic [1:0] gprsel, gprsel2;
    logic [1:0] npcop, npcop2;
    logic       gprwr, pcwr, irwr, dmwr, mem_req, cp0_wen, exl_set, exl_clr, int_pc;
    logic       gprwr2, pcwr2, irwr2, dmwr2, mem_req2, cp0_wen2, exl_set2, exl_clr2, int_pc2;
    logic [4:0] exc_code, exc_code2;
    logic [2:0] irq_id, irq_id2;
    logic [3:0] state, state2;

    int passed = 0;
    int failed = 0;
    int total  = 0;
    int irwr_cnt = 0;
    int irwr_base;

    always #5 clk = ~clk;

    mcyc_ctrl_ext dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .mf(mf), .zero(zero),
        .overflow(overflow), .int_req(int_req), .int_mask(int_mask), .exl(exl),
        .mem_rdy(mem_rdy), .aluop(aluop), .extop(extop), .bsel(bsel), .wdsel(wdsel),
        .gprsel(gprsel), .npcop(npcop), .gprwr(gprwr), .pcwr(pcwr), .irwr(irwr),
        .dmwr(dmwr), .mem_req(mem_req), .cp0_wen(cp0_wen), .exl_set(exl_set),
        .exl_clr(exl_clr), .int_pc(int_pc), .exc_code(exc_code), .irq_id(irq_id),
        .state(state)
    );

    mcyc_ctrl_ext #(.TRAP_OV(1'b0)) dut_nt (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .mf(mf), .zero(zero),
        .overflow(overflow), .int_req(int_req), .int_mask(int_mask), .exl(exl),
        .mem_rdy(mem_rdy), .aluop(aluop2), .extop(extop2), .bsel(bsel2), .wdsel(wdsel2),
        .gprsel(gprsel2), .npcop(npcop2), .gprwr(gprwr2), .pcwr(pcwr2), .irwr(irwr2),
        .dmwr(dmwr2), .mem_req(mem_req2), .cp0_wen(cp0_wen2), .exl_set(exl_set2),
        .exl_clr(exl_clr2), .int_pc(int_pc2), .exc_code(exc_code2), .irq_id(irq_id2),
        .state(state2)
    );

    always @(negedge clk) if (irwr === 1'b1) irwr_cnt <= irwr_cnt + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // One-cycle fetch: leaves both DUTs settled in DECODE.
    task automatic fetch(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] m);
        opcode  = op;
        funct   = fn;
        mf      = m;
        mem_rdy = 1'b1;
        #1;
        check("fetch_irwr", irwr, 1);
        cyc();
        mem_rdy = 1'b0;
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset
        #2 rst_n = 1'b0;
        #1;
        check("rst_state", state, 0);
        check("rst_exc_code", exc_code, 0);
        check("rst_irq_id", irq_id, 0);
        check("rst_mem_req", mem_req, 0);
        check("rst_irwr", irwr, 0);
        cyc();
        cyc();
        rst_n = 1'b0;
        rst_n = 1'b1;

        // addu with three wait cycles in FETCH: 4 + DECODE + EXE + AWB = 7 cycles
        irwr_base = irwr_cnt;
        opcode = 6'b000000; funct = 6'b100001; mem_rdy = 1'b0;
        #1;
        check("a_fetch_state", state, 0);
        check("a_fetch_memreq", mem_req, 1);
        check("a_fetch_irwr_wait", irwr, 0);
        check("a_fetch_npcop", npcop, 0);
        cyc();
        cyc();
        check("a_wait3_pcwr", pcwr, 0);
        cyc();
        mem_rdy = 1'b1;
        #1;
        check("a_rdy_irwr", irwr, 1);
        check("a_rdy_pcwr", pcwr, 1);
        cyc();
        mem_rdy = 1'b0;
        #1;
        check("a_decode_state", state, 1);
        check("a_decode_irwr", irwr, 0);
        check("a_decode_gprwr", gprwr, 0);
        cyc();
        check("a_exe_state", state, 6);
        cyc();
        check("a_awb_state", state, 7);
        check("a_awb_gprwr", gprwr, 1);
        check("a_awb_gprsel", gprsel, 2'b01);
        check("a_awb_aluop", aluop, 3'b000);
        cyc();
        check("a_back_fetch", state, 0);
        check("a_irwr_pulses", irwr_cnt - irwr_base, 1);

        // addi overflow: trap with TRAP_OV=1, write $30 with TRAP_OV=0
        fetch(6'b001000, 6'd0, 5'd0);
        cyc();
        cyc();
        overflow = 1'b1;
        #1;
        check("b_awb_gprwr_trap", gprwr, 0);
        check("b_awb_gprwr_notrap", gprwr2, 1);
        check("b_awb_gprsel_notrap", gprsel2, 2'b11);
        check("b_aluop_addi", aluop, 3'b100);
        cyc();
        overflow = 1'b0;
        #1;
        check("b_exc_state", state, 10);
        check("b_exc_code", exc_code, 12);
        check("b_exc_int_pc", int_pc, 1);
        check("b_exc_pcwr", pcwr, 1);
        check("b_exc_exl_set", exl_set, 1);
        check("b_notrap_state", state2, 0);
        cyc();
        check("b_after_state", state, 0);
        check("b_exc_code_held", exc_code, 12);

        // sw with masked interrupt 3 pending: deferred through waits, taken at completion
        int_req = 6'b001100; int_mask = 6'b001000; exl = 1'b0;
        fetch(6'b101011, 6'd0, 5'd0);
        check("c_decode_no_trap", state, 1);
        cyc();
        check("c_madr_state", state, 2);
        cyc();
        check("c_mwr_state", state, 5);
        check("c_mwr_dmwr", dmwr, 1);
        check("c_mwr_memreq", mem_req, 1);
        cyc();
        check("c_mwr_wait_state", state, 5);
        mem_rdy = 1'b1;
        #1;
        check("c_mwr_rdy_dmwr", dmwr, 1);
        cyc();
        mem_rdy = 1'b0;
        int_req = 6'd0; int_mask = 6'd0;
        #1;
        check("c_exc_state", state, 10);
        check("c_exc_code", exc_code, 0);
        check("c_irq_id", irq_id, 3);
        cyc();

        // eret with interrupt 4 pending and exl still set: no trap until the next ori
        exl = 1'b1; int_req = 6'b010000; int_mask = 6'b010000;
        fetch(6'b010000, 6'b011000, 5'b10000);
        cyc();
        check("e_jmp_state", state, 9);
        check("e_jmp_exl_clr", exl_clr, 1);
        check("e_jmp_pcwr", pcwr, 1);
        check("e_jmp_npcop", npcop, 2'b11);
        cyc();
        exl = 1'b0;
        check("e_no_exc", state, 0);
        fetch(6'b001101, 6'd0, 5'd0);
        check("e_ori_decode", state, 1);
        cyc();
        cyc();
        check("e_ori_awb_gprwr", gprwr, 1);
        check("e_ori_extop", extop, 2'b00);
        cyc();
        int_req = 6'd0; int_mask = 6'd0;
        #1;
        check("e_exc_state", state, 10);
        check("e_exc_code", exc_code, 0);
        check("e_irq_id", irq_id, 4);
        cyc();

        // Reserved opcode
        fetch(6'b111111, 6'd0, 5'd0);
        check("d_decode_gprwr", gprwr, 0);
        check("d_decode_dmwr", dmwr, 0);
        cyc();
        check("d_exc_state", state, 10);
        check("d_exc_code", exc_code, 10);
        check("d_exc_gprwr", gprwr, 0);
        cyc();

        // Reset asserted during an lw read wait
        fetch(6'b100011, 6'd0, 5'd0);
        cyc();
        cyc();
        check("f_mrd_state", state, 3);
        check("f_mrd_memreq", mem_req, 1);
        check("f_mrd_wdsel", wdsel, 3'b001);
        #2 rst_n = 1'b0;
        #1;
        check("f_rst_memreq", mem_req, 0);
        check("f_rst_state", state, 0);
        check("f_rst_exc_code", exc_code, 0);
        cyc();
        rst_n = 1'b1;
        opcode = 6'b000000; funct = 6'b100001; mem_rdy = 1'b1;
        #1;
        check("f_rel_state", state, 0);
        check("f_rel_memreq", mem_req, 1);
        cyc();
        mem_rdy = 1'b0;
        #1;
        check("f_rel_decode", state, 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
